// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared mode codes, finish marker and sequencer state encoding
package note_seq_pkg;
  localparam logic [1:0] NOTE_MODE_PLAY  = 2'd3;
  localparam logic [1:0] NOTE_MODE_LEARN = 2'd2;
  localparam logic [6:0] NOTE_FINISH     = 7'h7C;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_PRIME, SEQ_RUN, SEQ_DONE} seq_state_t;

  // Any mode code other than PLAY is treated as LEARN.
  function automatic logic is_play(input logic [1:0] m);
    return m == NOTE_MODE_PLAY;
  endfunction
endpackage

// File: rtl/note_fetch_pipe.sv
// note_fetch_pipe: tracks outstanding ROM reads so returning data lines up with a valid strobe
module note_fetch_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic i_issue,
  input  logic i_flush,
  output logic o_data_valid,
  output logic o_inflight
);
  logic [LATENCY-1:0] r_vld;

  // One valid bit per outstanding read; flush discards everything still in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_vld <= '0;
    else           r_vld <= i_flush ? '0 : (r_vld << 1) | LATENCY'(i_issue);
  end

  assign o_data_valid = r_vld[LATENCY-1];
  assign o_inflight   = |r_vld;
endmodule

// File: rtl/note_stream_sequencer.sv
// note_stream_sequencer: sliding window of upcoming song notes fed from an external ROM.
// Optional build macro NOTE_SEQ_LOOP_EN adds loop_in/loop_count for automatic song repeat.
module note_stream_sequencer
  import note_seq_pkg::*;
#(
  parameter int NOTE_BITS   = 7,
  parameter int WINDOW      = 5,
  parameter int ADDR_BITS   = 10,
  parameter int SONG_BITS   = 2,
  parameter int SONG_STRIDE = 250,
  parameter int NOTE_TICKS  = 25_000_000,
  parameter int ROM_LATENCY = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start,
  input  logic [SONG_BITS-1:0]        song_choice,
  input  logic [1:0]                  mode,
  input  logic                        advance_note,
  input  logic                        pause,
  output logic [ADDR_BITS-1:0]        rom_addr,
  input  logic [NOTE_BITS:0]          rom_data,
  output logic [WINDOW*NOTE_BITS-1:0] notes,
  output logic                        shifting_out,
  output logic                        busy,
  output logic                        finished
`ifdef NOTE_SEQ_LOOP_EN
  ,
  input  logic                        loop_in,
  output logic [3:0]                  loop_count
`endif
);
  localparam int NW = WINDOW * NOTE_BITS;
  localparam int TW = $clog2(NOTE_TICKS);
  localparam int PW = $clog2(WINDOW + ROM_LATENCY + 1);

  seq_state_t           r_state, w_state_n;
  logic [NW-1:0]        r_notes;
  logic [ADDR_BITS-1:0] r_addr, r_base, w_base;
  logic                 r_play, r_pend;
  logic [TW-1:0]        r_timer;
  logic [PW-1:0]        r_pcnt;
  logic                 w_issue, w_fin, w_loop, w_reprime, w_shift, w_flush, w_dv, w_infl;
  logic [NOTE_BITS-1:0] w_head;
  logic                 w_unused;

  assign w_base    = ADDR_BITS'(song_choice * SONG_STRIDE);
  assign w_head    = r_notes[NW-1 -: NOTE_BITS];
  assign w_reprime = w_fin & w_loop;
  assign w_flush   = start | w_fin;
  assign w_shift   = w_dv & ~start & ~w_fin & (r_state == SEQ_PRIME | r_state == SEQ_RUN);
  assign w_unused  = rom_data[NOTE_BITS];

  note_fetch_pipe #(.LATENCY(ROM_LATENCY)) u_pipe (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .i_issue      (w_issue),
    .i_flush      (w_flush),
    .o_data_valid (w_dv),
    .o_inflight   (w_infl)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= SEQ_IDLE;
    else           r_state <= w_state_n;
  end

  // Next state and fetch issue: start overrides all; finish stops fetching and drops in-flight data.
  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    w_fin     = 1'b0;
    if (start) w_state_n = SEQ_PRIME;
    else begin
      case (r_state)
        SEQ_PRIME: begin
          w_issue = r_pcnt < PW'(WINDOW);
          if (r_pcnt == PW'(WINDOW + ROM_LATENCY - 1)) w_state_n = SEQ_RUN;
        end
        SEQ_RUN: begin
          if (w_head == NOTE_BITS'(NOTE_FINISH)) begin
            w_fin     = 1'b1;
            w_state_n = w_loop ? SEQ_PRIME : SEQ_DONE;
          end else begin
            w_issue = r_play ? (!pause && r_timer == TW'(NOTE_TICKS - 1))
                    : r_pend ? (w_dv || !w_infl)
                    : (advance_note && !w_infl);
          end
        end
        default: ;
      endcase
    end
  end

  // Note window and ROM address: cleared/rebased on (re)start, shifted on returning data.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_notes <= '0;
      r_addr  <= '0;
    end else if (start) begin
      r_notes <= '0;
      r_addr  <= w_base;
    end else if (w_reprime) begin
      r_notes <= '0;
      r_addr  <= r_base;
    end else begin
      if (w_shift) r_notes <= {r_notes[NW-NOTE_BITS-1:0], rom_data[NOTE_BITS-1:0]};
      if (w_issue) r_addr <= r_addr + 1'b1;
    end
  end

  // Song base and play/learn mode are captured only when a song starts.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_base <= '0;
      r_play <= 1'b0;
    end else if (start) begin
      r_base <= w_base;
      r_play <= is_play(mode);
    end
  end

  // PLAY note timer and the single-entry LEARN advance queue; both idle outside RUN.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_timer <= '0;
      r_pend  <= 1'b0;
    end else if (start || w_fin || r_state != SEQ_RUN) begin
      r_timer <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_timer <= (!r_play || pause) ? r_timer
               : (r_timer == TW'(NOTE_TICKS - 1)) ? '0 : r_timer + 1'b1;
      r_pend  <= r_play ? 1'b0 : r_pend ? !w_issue : (advance_note && w_infl);
    end
  end

  // Cycle counter through PRIME: fetch slots first, then wait out the ROM latency.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_pcnt <= '0;
    else           r_pcnt <= (r_state == SEQ_PRIME && !start) ? r_pcnt + 1'b1 : '0;
  end

`ifdef NOTE_SEQ_LOOP_EN
  logic [3:0] r_loops;
  assign w_loop     = loop_in;
  assign loop_count = r_loops;

  // Completed-loop counter, saturating so it never wraps back to zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                            r_loops <= '0;
    else if (start)                           r_loops <= '0;
    else if (w_reprime && r_loops != 4'hF)    r_loops <= r_loops + 1'b1;
  end
`else
  assign w_loop = 1'b0;
`endif

  assign rom_addr     = r_addr;
  assign notes        = r_notes;
  assign shifting_out = w_shift;
  assign busy         = (r_state == SEQ_PRIME) | (r_state == SEQ_RUN);
  assign finished     = (r_state == SEQ_DONE);
endmodule

// File: tb/tb_note_stream_sequencer.sv
// tb_note_stream_sequencer: directed scoreboard bench with a 2-cycle-latency song ROM model
module tb_note_stream_sequencer;
  logic        clk_in = 1'b0, rst_n_in = 1'b0, start = 1'b0, advance_note = 1'b0, pause = 1'b0;
  logic [1:0]  song_choice = '0, mode = '0;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [34:0] notes;
  logic        shifting_out, busy, finished;
`ifdef NOTE_SEQ_LOOP_EN
  logic        loop_in = 1'b0;
  logic [3:0]  loop_count;
`endif
  logic [7:0]  rom [1024];
  logic [7:0]  d1, d2;
  logic [6:0]  q[$];
  int          nerr = 0, nchk = 0;

  note_stream_sequencer #(.WINDOW(5), .NOTE_TICKS(8), .ROM_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start(start), .song_choice(song_choice), .mode(mode),
    .advance_note(advance_note), .pause(pause), .rom_addr(rom_addr), .rom_data(rom_data),
    .notes(notes), .shifting_out(shifting_out), .busy(busy), .finished(finished)
`ifdef NOTE_SEQ_LOOP_EN
    , .loop_in(loop_in), .loop_count(loop_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Song ROM: address registered, data two cycles after the address is presented.
  always @(posedge clk_in) begin
    d1 <= rom[rom_addr];
    d2 <= d1;
  end
  assign rom_data = d2;

  function automatic logic [7:0] note_rom(int i);
    return {i[0], 7'((i * 37 + 11) % 100)};
  endfunction

  function automatic logic [34:0] win(int last);
    logic [34:0] w = '0;
    for (int i = 0; i < 5; i++) w = {w[27:0], rom[(last - 4 + i) & 1023][6:0]};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every shift must match the oldest expected ROM note.
  always @(negedge clk_in) begin
    if (shifting_out === 1'b1) begin
      chk("shift_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("shift_data", 64'(rom_data[6:0]), 64'(q.pop_front()));
    end
  end

  task automatic prime(int song, logic [1:0] md);
    int b = song * 250;
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(rom[(b + i) & 1023][6:0]);
    start = 1'b1; song_choice = 2'(song); mode = md;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("prime_addr", 64'(rom_addr), 64'((b + i) & 1023));
      chk("prime_busy", 64'(busy), 64'd1);
      tick();
    end
    tick();
    tick();
    chk("prime_win", 64'(notes), 64'(win(b + 4)));
    chk("prime_left", 64'(q.size()), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_finished", 64'(finished), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = note_rom(i);
    tick();
    tick();
    chk("rst_notes", 64'(notes), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_shift", 64'(shifting_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finished", 64'(finished), 64'd0);
    rst_n_in = 1'b1;
    tick();

    // PLAY song 1: steady shift cadence, then a 3-cycle pause.
    prime(1, 2'd3);
    for (int a = 255; a < 258; a++) q.push_back(rom[a][6:0]);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("play_shift", 64'(shifting_out), 64'(k == 9 || k == 17));
    end
    tick(); pause = 1'b1;
    tick(); tick();
    tick(); pause = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("pause_shift", 64'(shifting_out), 64'(k == 7));
    end
    tick();
    chk("play_win", 64'(notes), 64'(win(257)));
    chk("play_addr", 64'(rom_addr), 64'd258);

    // LEARN: three consecutive requests -> one fetch, one queued, one dropped.
    prime(1, 2'd2);
    q.push_back(rom[255][6:0]);
    q.push_back(rom[256][6:0]);
    for (int k = 0; k < 8; k++) begin
      advance_note = (k < 3);
      chk("learn_shift", 64'(shifting_out), 64'(k == 2 || k == 4));
      tick();
    end
    chk("learn_win", 64'(notes), 64'(win(256)));
    chk("learn_addr", 64'(rom_addr), 64'd257);

    // Finish marker reaches the head after two advances.
    rom[252] = 8'h7C;
`ifdef NOTE_SEQ_LOOP_EN
    loop_in = 1'b1;
    prime(1, 2'd2);
    q.push_back(rom[255][6:0]);
    q.push_back(rom[256][6:0]);
    for (int i = 0; i < 5; i++) q.push_back(rom[250 + i][6:0]);
    advance_note = 1'b1; tick(); advance_note = 1'b0; tick(); tick();
    advance_note = 1'b1; tick(); advance_note = 1'b0; tick(); tick(); tick();
    chk("loop_addr", 64'(rom_addr), 64'd250);
    chk("loop_count", 64'(loop_count), 64'd1);
    chk("loop_busy", 64'(busy), 64'd1);
    repeat (7) tick();
    chk("loop_win", 64'(notes), 64'(win(254)));
    chk("loop_left", 64'(q.size()), 64'd0);
    loop_in = 1'b0;
`endif
    prime(1, 2'd2);
    q.push_back(rom[255][6:0]);
    q.push_back(rom[256][6:0]);
    advance_note = 1'b1; tick(); advance_note = 1'b0; tick();
    chk("fin_shift1", 64'(shifting_out), 64'd1);
    tick(); advance_note = 1'b1; tick(); advance_note = 1'b0; tick();
    chk("fin_shift2", 64'(shifting_out), 64'd1);
    tick();
    chk("fin_not_yet", 64'(finished), 64'd0);
    tick();
    chk("fin_finished", 64'(finished), 64'd1);
    chk("fin_busy", 64'(busy), 64'd0);
    chk("fin_win", 64'(notes), 64'(win(256)));
    repeat (4) begin
      advance_note = 1'b1;
      tick();
      chk("done_shift", 64'(shifting_out), 64'd0);
    end
    advance_note = 1'b0;
    chk("done_win", 64'(notes), 64'(win(256)));
    chk("done_finished", 64'(finished), 64'd1);
    rom[252] = note_rom(252);

    // Restart on song 0 while a LEARN fetch is outstanding: the stale result must vanish.
    prime(1, 2'd2);
    advance_note = 1'b1; tick(); advance_note = 1'b0;
    prime(0, 2'd3);

    // Asynchronous reset with a PLAY fetch in flight.
    repeat (8) tick();
    rst_n_in = 1'b0;
    #1;
    chk("arst_notes", 64'(notes), 64'd0);
    chk("arst_addr", 64'(rom_addr), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_shift", 64'(shifting_out), 64'd0);
    tick(); tick();
    rst_n_in = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_shift", 64'(shifting_out), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
    end

    // Song 3 in LEARN, advancing past the top of the address space.
    prime(3, 2'd2);
    for (int i = 0; i < 272; i++) begin
      q.push_back(rom[(755 + i) & 1023][6:0]);
      advance_note = 1'b1; tick(); advance_note = 1'b0; tick(); tick();
    end
    chk("wrap_addr", 64'(rom_addr), 64'd3);
    chk("wrap_win", 64'(notes), 64'(win(1026)));
    chk("wrap_left", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
